// File: rtl/mvm_sched_pkg.sv
// Shared types and constants for the NoC injection arbiter.
package mvm_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned PKTCNT_W = 16;

  // Source-index width; a single source still needs one bit for GRANT_ID.
  function automatic int unsigned srcw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register carrying data, user, dest and last.
module axis_out_reg #(
  parameter int unsigned DATAW = 512,
  parameter int unsigned USERW = 2,
  parameter int unsigned DESTW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [DATAW-1:0] in_data_i,
  input  logic [USERW-1:0] in_user_i,
  input  logic [DESTW-1:0] in_dest_i,
  input  logic             in_last_i,
  output logic             in_ready_c_o,
  output logic             out_valid_o,
  output logic [DATAW-1:0] out_data_o,
  output logic [USERW-1:0] out_user_o,
  output logic [DESTW-1:0] out_dest_o,
  output logic             out_last_o,
  input  logic             out_ready_i
);

  assign in_ready_c_o = ~out_valid_o | out_ready_i;

  // Payload only moves on a load, so it stays put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_user_o  <= '0;
      out_dest_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (in_valid_i && in_ready_c_o) begin
      out_valid_o <= 1'b1;
      out_data_o  <= in_data_i;
      out_user_o  <= in_user_i;
      out_dest_o  <= in_dest_i;
      out_last_o  <= in_last_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mvm_inject_arbiter.sv
// Packet-granular round-robin arbiter onto the mesh [0][0] injection port.
// Optional per-source packet counters: define MVM_ARB_PKTCNT_EN.
module mvm_inject_arbiter
  import mvm_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATAW   = 512,
  parameter int unsigned USERW   = 2,
  parameter int unsigned DESTW   = 4,
  localparam int unsigned SRCW   = srcw(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       axis_s_tvalid_i,
  output logic [NUM_SRC-1:0]       axis_s_tready_o,
  input  logic [NUM_SRC*DATAW-1:0] axis_s_tdata_i,
  input  logic [NUM_SRC-1:0]       axis_s_tlast_i,
  input  logic [NUM_SRC*USERW-1:0] axis_s_tuser_i,
  input  logic [NUM_SRC*DESTW-1:0] axis_s_tdest_i,
  output logic                     axis_m_tvalid_o,
  input  logic                     axis_m_tready_i,
  output logic [DATAW-1:0]         axis_m_tdata_o,
  output logic                     axis_m_tlast_o,
  output logic [USERW-1:0]         axis_m_tuser_o,
  output logic [DESTW-1:0]         axis_m_tdest_o,
`ifdef MVM_ARB_PKTCNT_EN
  output logic [NUM_SRC*PKTCNT_W-1:0] pkt_cnt_o,
`endif
  output logic [SRCW-1:0]          grant_id_o
);

  arb_state_t      state_q, state_d;
  logic [SRCW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRCW-1:0] grant_q, grant_d;
  logic [SRCW-1:0] pick_idx;
  logic            pick_found;

  logic             sel_valid, sel_last;
  logic [DATAW-1:0] sel_data;
  logic [USERW-1:0] sel_user;
  logic [DESTW-1:0] sel_dest;
  logic             beat_valid, out_ready_c, accept, pkt_done;

  assign grant_id_o = grant_q;

  // First valid source at or after rr_ptr, wrapping to the low indices.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && axis_s_tvalid_i[i] && (SRCW'(i) >= rr_ptr_q)) begin
        pick_found = 1'b1;
        pick_idx   = SRCW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && axis_s_tvalid_i[i]) begin
        pick_found = 1'b1;
        pick_idx   = SRCW'(i);
      end
    end
  end

  // Mux the granted source's stream.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    sel_dest  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SRCW'(i)) begin
        sel_valid = axis_s_tvalid_i[i];
        sel_last  = axis_s_tlast_i[i];
        sel_data  = axis_s_tdata_i[i*DATAW +: DATAW];
        sel_user  = axis_s_tuser_i[i*USERW +: USERW];
        sel_dest  = axis_s_tdest_i[i*DESTW +: DESTW];
      end
    end
  end

  assign beat_valid = (state_q == BUSY) & sel_valid;
  assign accept     = beat_valid & out_ready_c;
  assign pkt_done   = accept & sel_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Grant is taken in IDLE (bubble cycle) and held until the TLAST beat is accepted.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    axis_s_tready_o = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (grant_q == SRCW'(i)) axis_s_tready_o[i] = out_ready_c;
        end
        if (pkt_done) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == SRCW'(NUM_SRC - 1)) ? '0 : grant_q + SRCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  axis_out_reg #(
    .DATAW (DATAW),
    .USERW (USERW),
    .DESTW (DESTW)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (beat_valid),
    .in_data_i    (sel_data),
    .in_user_i    (sel_user),
    .in_dest_i    (sel_dest),
    .in_last_i    (sel_last),
    .in_ready_c_o (out_ready_c),
    .out_valid_o  (axis_m_tvalid_o),
    .out_data_o   (axis_m_tdata_o),
    .out_user_o   (axis_m_tuser_o),
    .out_dest_o   (axis_m_tdest_o),
    .out_last_o   (axis_m_tlast_o),
    .out_ready_i  (axis_m_tready_i)
  );

`ifdef MVM_ARB_PKTCNT_EN
  // Completed-packet counters, saturating at all ones.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    logic [PKTCNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (pkt_done && (grant_q == SRCW'(g)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + PKTCNT_W'(1);
      end
    end
    assign pkt_cnt_o[g*PKTCNT_W +: PKTCNT_W] = cnt_q;
  end
`endif

endmodule
